// File: rtl/macg_byte_packer_if.sv
// ============================================================================
// Module   : macg_byte_packer_if
// Brief    : AXI-Stream bundle (tdata/tvalid/tlast/tready) with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface macg_byte_packer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/macg_byte_packer.sv
// ============================================================================
// Module   : macg_byte_packer
// Brief    : Packs an 8-bit AXI-Stream big-endian into 64-bit cipher blocks and
//            pads the final block of each frame. Define MACG_PKCS7_PAD_EN for
//            PKCS#7 padding; otherwise the frame tail is zero padded.
// Revision : 1.0
// ============================================================================
`default_nettype none

module macg_byte_packer #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  macg_byte_packer_if.slave    s_axis,
  macg_byte_packer_if.master   m_axis,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_PAD = 1'b1
  } state_t;

  localparam logic [63:0] C_PAD_BLOCK = 64'h0808080808080808;

  state_t               r_state;
  logic [2:0]           r_idx;
  logic [63:0]          r_acc;
  logic [63:0]          r_m_data;
  logic                 r_m_valid;
  logic                 r_m_last;
  logic [BLK_CNT_W-1:0] r_blk_cnt;

  logic                 w_out_free;
  logic                 w_s_hs;
  logic                 w_m_hs;
  logic [7:0]           w_pad_byte;
  logic                 w_block_last;
  logic [63:0]          w_block;

  assign w_out_free = !r_m_valid || m_axis.tready;
  assign w_s_hs     = s_axis.tvalid && s_axis.tready;
  assign w_m_hs     = r_m_valid && m_axis.tready;

  assign s_axis.tready = (r_state == ST_ACC) && w_out_free && !rst;

  assign m_axis.tdata  = r_m_data;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tlast  = r_m_last;
  assign blk_cnt       = r_blk_cnt;

`ifdef MACG_PKCS7_PAD_EN
  // Pad value is the number of missing bytes, 8-n with n = idx+1.
  assign w_pad_byte   = {5'd0, 3'd7 - r_idx};
  // A full final block is followed by a dedicated pad block, so it is not last.
  assign w_block_last = s_axis.tlast && (r_idx != 3'd7);
`else
  assign w_pad_byte   = 8'h00;
  assign w_block_last = s_axis.tlast;
`endif

  // Held bytes, the incoming byte at the current index, padding after it.
  always_comb begin
    w_block = '0;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) < r_idx) begin
        w_block[63-8*k -: 8] = r_acc[63-8*k -: 8];
      end else if (3'(k) == r_idx) begin
        w_block[63-8*k -: 8] = s_axis.tdata;
      end else begin
        w_block[63-8*k -: 8] = w_pad_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ACC;
      r_idx     <= 3'd0;
      r_acc     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_blk_cnt <= '0;
    end else begin
      if (w_m_hs) begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
        r_m_valid <= 1'b0;
      end

      case (r_state)
        ST_ACC: begin
          if (w_s_hs) begin
            if (s_axis.tlast || (r_idx == 3'd7)) begin
              r_m_data  <= w_block;
              r_m_valid <= 1'b1;
              r_m_last  <= w_block_last;
              r_idx     <= 3'd0;
              r_acc     <= '0;
`ifdef MACG_PKCS7_PAD_EN
              if (s_axis.tlast && (r_idx == 3'd7)) begin
                r_state <= ST_PAD;
              end
`endif
            end else begin
              r_acc <= w_block;
              r_idx <= r_idx + 3'd1;
            end
          end
        end

        ST_PAD: begin
          if (w_out_free) begin
            r_m_data  <= C_PAD_BLOCK;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b1;
            r_state   <= ST_ACC;
          end
        end

        default: r_state <= ST_ACC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_macg_byte_packer.sv
// ============================================================================
// Module   : tb_macg_byte_packer
// Brief    : Scoreboard bench for macg_byte_packer (4-bit block counter).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_macg_byte_packer;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] blk_cnt;

  int   total;
  int   bad;
  exp_t q[$];

  logic [3:0]  cnt_model;
  bit          stall_prev;
  logic [63:0] held_d;
  logic        held_l;

  macg_byte_packer_if #(.DATA_W(8))  s_if();
  macg_byte_packer_if #(.DATA_W(64)) m_if();

  macg_byte_packer #(.BLK_CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .blk_cnt (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      cnt_model  = 4'd0;
      stall_prev = 1'b0;
    end else begin
      if (m_if.tvalid && !m_if.tready) begin
        check("s_tready_in_stall", {63'd0, s_if.tready}, 64'd0);
        if (stall_prev) begin
          check("hold_tdata", m_if.tdata, held_d);
          check("hold_tlast", {63'd0, m_if.tlast}, {63'd0, held_l});
        end
        stall_prev = 1'b1;
        held_d     = m_if.tdata;
        held_l     = m_if.tlast;
      end else begin
        stall_prev = 1'b0;
      end
      if (m_if.tvalid && m_if.tready) begin
        check("blk_cnt_at_hs", {60'd0, blk_cnt}, {60'd0, cnt_model});
        cnt_model = cnt_model + 4'd1;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_block: got %h with no expected block", m_if.tdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("block_tdata", m_if.tdata, e.d);
          check("block_tlast", {63'd0, m_if.tlast}, {63'd0, e.l});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = s_if.tready;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h not accepted, required accept within 64 cycles", d);
    end
  endtask

  task automatic send_seq(input logic [7:0] first, input logic [7:0] step,
                          input int cnt, input logic last_on_end);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < cnt; i++) begin
      send_byte(b, last_on_end && (i == cnt - 1));
      b = b + step;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d blocks pending, required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [63:0] blk;
    logic [7:0]  b;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", {63'd0, s_if.tready}, 64'd0);
    check("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    check("rst_m_tdata",  m_if.tdata, 64'd0);
    check("rst_m_tlast",  {63'd0, m_if.tlast}, 64'd0);
    check("rst_blk_cnt",  {60'd0, blk_cnt}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full block, no tlast: visible one cycle after the 8th byte.
    e = '{d: 64'h0102030405060708, l: 1'b0}; q.push_back(e);
    send_seq(8'h01, 8'h01, 8, 1'b0);
    check("t1_latency_valid", {63'd0, m_if.tvalid}, 64'd1);
    check("t1_latency_data",  m_if.tdata, 64'h0102030405060708);
    check("t1_latency_last",  {63'd0, m_if.tlast}, 64'd0);
    drain();
    check("t1_blk_cnt", {60'd0, blk_cnt}, 64'd1);

    // Short final block.
`ifdef MACG_PKCS7_PAD_EN
    e = '{d: 64'hAABBCC0505050505, l: 1'b1}; q.push_back(e);
`else
    e = '{d: 64'hAABBCC0000000000, l: 1'b1}; q.push_back(e);
`endif
    send_seq(8'hAA, 8'h11, 3, 1'b1);
    drain();

    // Full final block.
`ifdef MACG_PKCS7_PAD_EN
    e = '{d: 64'h1112131415161718, l: 1'b0}; q.push_back(e);
    e = '{d: 64'h0808080808080808, l: 1'b1}; q.push_back(e);
    send_seq(8'h11, 8'h01, 8, 1'b1);
    check("t3_s_tready_pad", {63'd0, s_if.tready}, 64'd0);
`else
    e = '{d: 64'h1112131415161718, l: 1'b1}; q.push_back(e);
    send_seq(8'h11, 8'h01, 8, 1'b1);
    check("t3_s_tready_nopad", {63'd0, s_if.tready}, 64'd1);
`endif
    drain();

    // Backpressure with the next bytes already offered.
    m_if.tready = 1'b0;
    e = '{d: 64'hA0A1A2A3A4A5A6A7, l: 1'b0}; q.push_back(e);
    send_seq(8'hA0, 8'h01, 8, 1'b0);
    e = '{d: 64'h2122232425262728, l: 1'b0}; q.push_back(e);
    fork
      send_seq(8'h21, 8'h01, 8, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    drain();

    // Reset mid-block discards the partial bytes.
    send_seq(8'h31, 8'h01, 5, 1'b0);
    do_reset();
    check("t5_post_rst_cnt", {60'd0, blk_cnt}, 64'd0);
    e = '{d: 64'h3132333435363738, l: 1'b0}; q.push_back(e);
    send_seq(8'h31, 8'h01, 8, 1'b0);
    check("t5_cnt_before_hs", {60'd0, blk_cnt}, 64'd0);
    check("t5_valid", {63'd0, m_if.tvalid}, 64'd1);
    drain();

    // Counter wrap: 17 blocks on a 4-bit counter.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      b = 8'(k * 8);
      for (int j = 0; j < 8; j++) blk[63-8*j -: 8] = b + 8'(j);
      e = '{d: blk, l: 1'b0}; q.push_back(e);
      send_seq(b, 8'h01, 8, 1'b0);
    end
    drain();
    check("t6_blk_cnt_wrap", {60'd0, blk_cnt}, 64'd1);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
